rgb_led_sequencer: RTL and testbench
====================================

Name: rgb_led_sequencer

Overview:
- Parametrised multi-channel RGB LED pattern generator, fully synchronous to one clock. No derived or ripple clocks.
- A programmable prescaler produces a one-cycle tick. Each tick advances a 3-bit colour sequence in one of four modes.
- Every channel drives seq, optionally inverted, gated by a PWM brightness dimmer.
- Sits between board top-level LED pins and control logic/VIO; replaces fixed-rate, fixed-pattern blinkers.

Parameters:
- NUM_CH, 2, number of RGB LED channels (3 pins each).
- CNT_W, 32, prescaler counter and period width.
- PWM_BITS, 4, brightness resolution; PWM frame is 2**PWM_BITS cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active low.
- en  in  1  1 = prescaler runs and auto-advances.
- mode  in  2  sequence mode: 0 up, 1 down, 2 walk, 3 hold.
- period  in  CNT_W  a tick occurs every period+1 cycles.
- step  in  1  single-step request, honoured only while en=0.
- brightness  in  PWM_BITS  duty; 0 = off, all-ones = full on.
- invert_mask  in  NUM_CH  bit i=1 inverts channel i colour.
- rgb  out  3*NUM_CH  channel i on rgb[3i+2:3i], bit2=R, bit1=G, bit0=B.
- seq  out  3  current sequence value.
- tick  out  1  one-cycle strobe marking a sequence advance.

Behaviour:
- Reset: rst_n low asynchronously clears prescaler cnt, pwm_cnt, seq, tick and rgb to 0.
  - Reset may assert at any cycle; state resumes from 0 on the first edge after deassert.
- Prescaler, en=1:
  - If cnt >= period: cnt <= 0 and tick <= 1 on that edge.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
  - The >= compare means lowering period mid-count ticks on the next edge, never wraps through 2**CNT_W.
  - period=0 gives a tick every cycle.
- Prescaler, en=0:
  - cnt holds.
  - tick <= step, so each cycle step is high yields one tick.
  - Control sends step as a one-cycle pulse.
  - step is ignored while en=1.
- en toggling: cnt is not cleared. Resuming continues the count.
- Sequence update: seq updates on the same edge that sets tick=1, so the new seq is visible in the tick-high cycle.
  - Mode sampled at that edge:
  - mode 0: seq+1, wrapping 7->0.
  - mode 1: seq-1, wrapping 0->7.
  - mode 2: 001->010->100->001. Any non-one-hot value, including 000, goes to 001.
  - mode 3: seq holds. tick still pulses.
  - A mode change takes effect on the next tick. seq is not reset by a mode change.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter, +1 every clk regardless of en, wrapping.
  - pwm_on = (brightness == all-ones) OR (pwm_cnt < brightness).
  - Duty is brightness/2**PWM_BITS, except all-ones gives 100%.
- Output: rgb registered once.
  - Per channel i: rgb[3i+:3] <= pwm_on ? (seq XOR {3{invert_mask[i]}}) : 3'b000.
  - rgb lags seq by exactly 1 cycle.
  - brightness and invert_mask changes appear on rgb 1 cycle later.
- Width rule: all prescaler arithmetic is CNT_W bits, unsigned. seq arithmetic is modulo 8.

Test Plan:
- Reset/idle: rst_n=0 mid-run, then en=1, period=3, mode=0, brightness=all-ones, invert_mask=2'b10.
  - Required: outputs 0 during reset.
  - Required: tick on cycles 4, 8, 12 after deassert.
  - Required: seq=1, 2, 3 respectively.
  - Required: rgb={~seq, seq} one cycle after each seq change.
- Wrap and modes: period=0, mode=0 from seq=6 -> seq 7, 0, 1.
  - Switch to mode 1 -> 0, 7, 6.
  - Switch to mode 2 from seq=6 -> 001, 010, 100, 001.
  - mode 3 -> seq holds while tick pulses every cycle.
- Step: en=0, single-cycle step pulses at three arbitrary cycles.
  - Required: exactly three one-cycle ticks, seq +3, cnt unchanged.
  - With en=1, a step pulse produces no extra tick.
- Period shrink: period=100, wait until cnt=50, write period=10.
  - Required: tick on the next edge, then every 11 cycles.
- PWM: PWM_BITS=4, brightness=4 -> rgb nonzero exactly 4 of every 16 cycles.
  - brightness=0 -> rgb always 0.
  - brightness=15 -> rgb never gated.
- Async reset mid-tick: assert rst_n low between edges on a tick cycle.
  - Required: tick, seq and rgb drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: multi-channel RGB LED pattern generator.
//
// A programmable prescaler emits a one-cycle tick every period+1 clocks (or one
// tick per step pulse while en is low). Each tick advances a 3-bit colour
// sequence: count up, count down, walk a one-hot bit, or hold. Every channel
// shows the sequence (optionally inverted), gated by a PWM brightness dimmer.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           1 = prescaler runs and auto-advances
//   mode         0 up, 1 down, 2 walk, 3 hold
//   period       tick every period+1 cycles
//   step         single-step request, honoured only while en=0
//   brightness   PWM duty; 0 = off, all-ones = always on
//   invert_mask  bit i inverts the colour of channel i
//   rgb          channel i on rgb[3i+2:3i] (R,G,B), registered
//   seq          current sequence value
//   tick         one-cycle strobe, high in the cycle seq shows its new value
module rgb_led_sequencer #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      period,
  input  logic                  step,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic [NUM_CH-1:0]     invert_mask,
  output logic [3*NUM_CH-1:0]   rgb,
  output logic [2:0]            seq,
  output logic                  tick
);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]          seq_q, seq_d;
  logic                tick_q, tick_d;
  logic [3*NUM_CH-1:0] rgb_q, rgb_d;
  logic                pwm_on;

  // Prescaler. The >= compare makes a period lowered mid-count tick on the next
  // edge instead of counting up through the full counter range.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q >= period) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // Count is frozen, not cleared, so re-enabling resumes where it left off.
      tick_d = step;
    end
  end

  // Sequence advances on the same edge that raises tick.
  always_comb begin
    seq_d = seq_q;
    if (tick_d) begin
      unique case (mode)
        2'd0: seq_d = seq_q + 3'd1;
        2'd1: seq_d = seq_q - 3'd1;
        2'd2: begin
          unique case (seq_q)
            3'b001:  seq_d = 3'b010;
            3'b010:  seq_d = 3'b100;
            default: seq_d = 3'b001; // recovers from any non-one-hot value
          endcase
        end
        default: seq_d = seq_q;
      endcase
    end
  end

  // Free-running PWM frame counter, independent of en.
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign pwm_on    = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_q < brightness);

  // Output stage samples the current seq, so rgb lags seq by one cycle.
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rgb_d[3*i +: 3] = pwm_on ? (seq_q ^ {3{invert_mask[i]}}) : 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pwm_cnt_q <= '0;
      seq_q     <= '0;
      tick_q    <= 1'b0;
      rgb_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      seq_q     <= seq_d;
      tick_q    <= tick_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb  = rgb_q;
  assign seq  = seq_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
module tb_rgb_led_sequencer;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned PWM_BITS = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [1:0]            mode;
  logic [CNT_W-1:0]      period;
  logic                  step;
  logic [PWM_BITS-1:0]   brightness;
  logic [NUM_CH-1:0]     invert_mask;
  logic [3*NUM_CH-1:0]   rgb;
  logic [2:0]            seq;
  logic                  tick;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_led_sequencer #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .period      (period),
    .step        (step),
    .brightness  (brightness),
    .invert_mask (invert_mask),
    .rgb         (rgb),
    .seq         (seq),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [CNT_W-1:0]    m_cnt;
  logic [PWM_BITS-1:0] m_pwm;
  logic [2:0]          m_seq;
  logic                m_tick;
  logic [3*NUM_CH-1:0] m_rgb;

  function automatic logic [2:0] next_seq(input logic [2:0] s, input logic [1:0] md);
    case (md)
      2'd0:    return s + 3'd1;
      2'd1:    return s + 3'd7;
      2'd2:    return (s == 3'd1) ? 3'd2 : (s == 3'd2) ? 3'd4 : 3'd1;
      default: return s;
    endcase
  endfunction

  function automatic logic [3*NUM_CH-1:0] show(input logic [2:0] s,
                                               input logic [PWM_BITS-1:0] p);
    logic [3*NUM_CH-1:0] r;
    logic lit;
    lit = (brightness == {PWM_BITS{1'b1}}) || (p < brightness);
    r = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++)
      r[3*ch +: 3] = lit ? (invert_mask[ch] ? ~s : s) : 3'b000;
    return r;
  endfunction

  function automatic logic advance(input logic [CNT_W-1:0] c);
    return en ? (c >= period) : step;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= '0;
      m_pwm  <= '0;
      m_seq  <= '0;
      m_tick <= 1'b0;
      m_rgb  <= '0;
    end else begin
      m_rgb  <= show(m_seq, m_pwm);
      if (en) m_cnt <= (m_cnt >= period) ? '0 : m_cnt + CNT_W'(1);
      m_tick <= advance(m_cnt);
      if (advance(m_cnt)) m_seq <= next_seq(m_seq, mode);
      m_pwm  <= m_pwm + PWM_BITS'(1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_seq",  32'(seq),  32'(m_seq));
    check("model_rgb",  32'(rgb),  32'(m_rgb));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int cnt_ticks;
  int cnt_lit;
  logic [3*NUM_CH-1:0] rgb_tab [1:3];

  initial begin
    rgb_tab[1] = 6'b110_001;
    rgb_tab[2] = 6'b101_010;
    rgb_tab[3] = 6'b100_011;

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; period = 32'd0; step = 1'b0;
    brightness = 4'hF; invert_mask = 2'b10;
    edges(2);
    #3 rst_n = 1'b1;

    // Run, then reset mid-run.
    en = 1'b1;
    edges(6);
    check("prerun_seq", 32'(seq), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_seq",  32'(seq),  32'd0);
    check("reset_rgb",  32'(rgb),  32'd0);
    edges(2);
    period = 32'd3; mode = 2'd0; brightness = 4'hF; invert_mask = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      edges(1);
      if (e <= 12) check("p3_tick", 32'(tick), 32'((e % 4) == 0));
      if (e % 4 == 0) check("p3_seq", 32'(seq), 32'(e / 4));
      if (e % 4 == 1 && e > 1) check("p3_rgb", 32'(rgb), 32'(rgb_tab[e / 4]));
    end

    // Wrap and modes at period 0.
    period = 32'd0;
    edges(3);
    check("to_six", 32'(seq), 32'd6);
    foreach (rgb_tab[k]) begin
      edges(1);
      check("up_wrap", 32'(seq), (k == 1) ? 32'd7 : (k == 2) ? 32'd0 : 32'd1);
    end
    mode = 2'd1;
    for (int k = 0; k < 3; k++) begin
      edges(1);
      check("down_wrap", 32'(seq), (k == 0) ? 32'd0 : (k == 1) ? 32'd7 : 32'd6);
    end
    mode = 2'd2;
    for (int k = 0; k < 4; k++) begin
      edges(1);
      check("walk", 32'(seq), (k == 1) ? 32'd2 : (k == 2) ? 32'd4 : 32'd1);
    end
    mode = 2'd3;
    for (int k = 0; k < 4; k++) begin
      edges(1);
      check("hold_seq",  32'(seq),  32'd1);
      check("hold_tick", 32'(tick), 32'd1);
    end

    // Step while disabled; count must stay frozen at 5.
    mode = 2'd0; period = 32'd20;
    edges(5);
    en = 1'b0;
    cnt_ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step = (i == 2 || i == 6 || i == 10);
      edges(1);
      cnt_ticks += int'(tick);
    end
    step = 1'b0;
    check("step_ticks", 32'(cnt_ticks), 32'd3);
    check("step_seq",   32'(seq),       32'd4);
    en = 1'b1;
    cnt_ticks = 0;
    for (int i = 1; i <= 16; i++) begin
      step = (i == 3);
      edges(1);
      if (i < 16) cnt_ticks += int'(tick);
    end
    step = 1'b0;
    check("resume_no_tick", 32'(cnt_ticks), 32'd0);
    check("resume_tick",    32'(tick),      32'd1);
    check("resume_seq",     32'(seq),       32'd5);

    // Period shrink mid-count.
    period = 32'd100;
    edges(50);
    period = 32'd10;
    edges(1);
    check("shrink_first", 32'(tick), 32'd1);
    for (int i = 1; i <= 22; i++) begin
      edges(1);
      check("shrink_tick", 32'(tick), 32'((i % 11) == 0));
    end

    // PWM gating with seq frozen.
    en = 1'b0; brightness = 4'd4;
    edges(1);
    for (int w = 0; w < 2; w++) begin
      cnt_lit = 0;
      for (int i = 0; i < 16; i++) begin
        edges(1);
        cnt_lit += int'(rgb != '0);
      end
      check("pwm_b4", 32'(cnt_lit), 32'd4);
    end
    brightness = 4'd0;
    edges(1);
    cnt_lit = 0;
    for (int i = 0; i < 32; i++) begin
      edges(1);
      cnt_lit += int'(rgb != '0);
    end
    check("pwm_b0", 32'(cnt_lit), 32'd0);
    brightness = 4'hF;
    edges(1);
    cnt_lit = 0;
    for (int i = 0; i < 32; i++) begin
      edges(1);
      cnt_lit += int'(rgb != '0);
    end
    check("pwm_b15", 32'(cnt_lit), 32'd32);

    // Asynchronous reset in a tick-high cycle.
    en = 1'b1; period = 32'd0; mode = 2'd0;
    edges(3);
    #2;
    check("pre_async_tick", 32'(tick), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_tick", 32'(tick), 32'd0);
    check("async_seq",  32'(seq),  32'd0);
    check("async_rgb",  32'(rgb),  32'd0);
    edges(2);
    @(negedge clk);
    rst_n = 1'b1;
    edges(2);
    check("post_reset_seq", 32'(seq), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
